fp_convert_seq: RTL
===================

Name: fp_convert_seq

Overview:
Multi-cycle, parametrised converter from IN_W-bit two's-complement integer to sign / EXP_W-bit exponent / SIG_W-bit significand floating point, with round-to-nearest on the first dropped bit and saturation.
- Normalises iteratively: one left shift per cycle. Trades latency for area.
- Valid/ready handshake on both sides, so it can sit between the input register stage and the display/encode stage of the datapath.

Parameters:
IN_W, 12, input integer width (two's complement), must be > SIG_W
EXP_W, 3, exponent width; max exponent EMAX = 2^EXP_W-1
SIG_W, 4, significand width (explicit leading bit, no hidden bit)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  din is valid
in_ready  output  1  block can accept a sample (high only in IDLE)
din  input  IN_W  two's-complement sample
out_valid  output  1  result valid, held until accepted
out_ready  input  1  downstream accepts result
sign  output  1  sign of result (din MSB)
exp  output  EXP_W  exponent
sig  output  SIG_W  significand
sat  output  1  result saturated (exp=EMAX, sig=all ones)

Behaviour:
- Reset: one clock; asynchronous, active-low reset. While rst_n=0: state=IDLE, in_ready=0, out_valid=0, sign/exp/sig/sat=0. After release: in_ready=1 from the first clock edge onward. Reset asserted mid-conversion aborts it with no output.
- Value model: value = sig * 2^exp. E0 = IN_W-SIG_W; the internal exponent counter is clog2(E0+1) bits wide.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: sign_r=din[IN_W-1]; mag=|din| as IN_W-bit unsigned (most negative maps to 2^(IN_W-1), no overflow); cnt=E0; go to NORM.
- State NORM: each cycle,
  - If mag[IN_W-1]==1 or cnt==0: go to ROUND.
  - Otherwise: mag<<=1, cnt-=1.
- State ROUND (1 cycle), with s=mag[IN_W-1 -: SIG_W] and r=mag[IN_W-1-SIG_W]:
  - s2 = s + r, computed in SIG_W+1 bits.
  - If s2 overflows: s2 = 1 followed by zeros (SIG_W bits), cnt+1.
  - If resulting exponent > EMAX: exp=EMAX, sig=all ones, sat=1.
  - Else exp=cnt, sig=s2, sat=0.
  - Outputs are registered here; go to DONE.
- State DONE:
  - out_valid=1; outputs stable.
  - On out_ready: go to IDLE, out_valid=0 next cycle.
  - No new sample is accepted in the same cycle (in_ready=0 in DONE).
- Latency: out_valid rises k+2 cycles after the capture edge, with k = min(leading zeros of mag, E0). Max E0+2.
- Throughput: one sample per (latency + 1 + out_ready wait) cycles.
- Zero input: k=E0, exp=0, sig=0, sat=0, sign=0.
- Negative values: sign=1; magnitude is encoded identically to the positive case.
- in_valid while not in IDLE: ignored. din is not sampled.
- out_ready while not in DONE: ignored.

Decomposition:
- Package fp_convert_pkg: state enum (IDLE, NORM, ROUND, DONE); clog2 width function; E0/EMAX localparam helpers.
- Sub-module fp_round_sat: combinational rounding + exponent-increment + saturation (inputs s, r, cnt; outputs exp, sig, sat), instantiated in ROUND.

Test Plan:
- din=12'b0000_0000_0111 -> exp=000, sig=0111, sat=0, sign=0; out_valid at capture+10 (k=8).
- din=12'b0000_0011_1011 (59) -> pre-round sig 1110 with round bit 1 -> exp=010, sig=1111, sat=0; latency 8.
- din=248 (1111_1000) -> round carries out -> sig=1000, exp=101 (=256).
- din=12'h800 (-2048) -> sign=1, exp=111, sig=1111, sat=1; latency 2. din=12'h7FF -> exp=111, sig=1111, sat=1 (via round overflow).
- Hold out_ready=0 for 5 cycles in DONE while toggling in_valid/din -> outputs stable, in_ready=0, no capture; out_ready=1 -> IDLE next cycle.
- Deassert rst_n mid-NORM -> all outputs 0 immediately (asynchronously); after release, convert din=0 -> exp=0, sig=0, sign=0, latency 10.

Source files
------------

// File: rtl/fp_convert_pkg.sv
// Shared types and elaboration-time helpers for the integer-to-float converter.
package fp_convert_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Ceiling log2; callers guarantee v >= 2.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Exponent of the unshifted input: all IN_W-SIG_W low bits dropped.
  function automatic int calc_e0(input int in_w, input int sig_w);
    return in_w - sig_w;
  endfunction

  function automatic int calc_emax(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fp_round_sat.sv
// Round-to-nearest on the first dropped bit, exponent bump on carry-out,
// and clamp to the largest representable value when the exponent overflows.
module fp_round_sat
  import fp_convert_pkg::*;
#(
  parameter int EXP_W = 3,
  parameter int SIG_W = 4,
  parameter int CNT_W = 4
) (
  input  logic [SIG_W-1:0] s,
  input  logic             r,
  input  logic [CNT_W-1:0] cnt,
  output logic [EXP_W-1:0] exp,
  output logic [SIG_W-1:0] sig,
  output logic             sat
);

  localparam int EMAX = calc_emax(EXP_W);

  logic [SIG_W:0]   s2;
  logic [CNT_W:0]   e_full;
  logic [SIG_W-1:0] sig_rnd;

  // Add the round bit; a carry-out renormalises to 100..0 with one more exponent.
  always_comb begin
    s2      = {1'b0, s} + {{SIG_W{1'b0}}, r};
    e_full  = {1'b0, cnt};
    sig_rnd = s2[SIG_W-1:0];
    if (s2[SIG_W]) begin
      sig_rnd = {1'b1, {(SIG_W-1){1'b0}}};
      e_full  = e_full + {{CNT_W{1'b0}}, 1'b1};
    end
  end

  // Exponent beyond EMAX cannot be encoded: saturate.
  always_comb begin
    if (int'(e_full) > EMAX) begin
      exp = EXP_W'(EMAX);
      sig = '1;
      sat = 1'b1;
    end else begin
      exp = EXP_W'(e_full);
      sig = sig_rnd;
      sat = 1'b0;
    end
  end

endmodule

// File: rtl/fp_convert_seq.sv
// Sequential two's-complement integer to sign/exponent/significand converter.
// Normalises one bit per cycle, then rounds and saturates in a single cycle.
//
// state | meaning
// IDLE  | ready for a sample, in_ready=1
// NORM  | shifting magnitude left until MSB set or exponent reaches 0
// ROUND | round/saturate and register the result
// DONE  | result held with out_valid=1 until out_ready
module fp_convert_seq
  import fp_convert_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int SIG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign,
  output logic [EXP_W-1:0] exp,
  output logic [SIG_W-1:0] sig,
  output logic             sat
);

  localparam int E0    = calc_e0(IN_W, SIG_W);
  localparam int CNT_W = clog2(E0 + 1);

  state_t           state;
  logic [IN_W-1:0]  mag;
  logic [CNT_W-1:0] cnt;
  logic             sign_r;
  logic [IN_W-1:0]  din_mag;
  logic [EXP_W-1:0] rs_exp;
  logic [SIG_W-1:0] rs_sig;
  logic             rs_sat;

  // Magnitude as unsigned; the most negative input maps to 100..0 without overflow.
  always_comb begin
    din_mag = din[IN_W-1] ? (~din + {{(IN_W-1){1'b0}}, 1'b1}) : din;
  end

  fp_round_sat #(
    .EXP_W (EXP_W),
    .SIG_W (SIG_W),
    .CNT_W (CNT_W)
  ) u_round_sat (
    .s   (mag[IN_W-1 -: SIG_W]),
    .r   (mag[IN_W-1-SIG_W]),
    .cnt (cnt),
    .exp (rs_exp),
    .sig (rs_sig),
    .sat (rs_sat)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mag       <= '0;
      cnt       <= '0;
      sign_r    <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      sign      <= 1'b0;
      exp       <= '0;
      sig       <= '0;
      sat       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sign_r   <= din[IN_W-1];
            mag      <= din_mag;
            cnt      <= CNT_W'(E0);
            in_ready <= 1'b0;
            state    <= NORM;
          end else begin
            in_ready <= 1'b1;
          end
        end
        NORM: begin
          if (mag[IN_W-1] || (cnt == '0)) begin
            state <= ROUND;
          end else begin
            mag <= {mag[IN_W-2:0], 1'b0};
            cnt <= cnt - CNT_W'(1);
          end
        end
        ROUND: begin
          sign      <= sign_r;
          exp       <= rs_exp;
          sig       <= rs_sig;
          sat       <= rs_sat;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
